reg_dump_reader: RTL

//  Debug read-out engine for the 32x32 register file. On a start pulse it walks x0..x(NUM_REGS-1)

---
 rtl/reg_dump_reader_pkg.sv | 20 ++
 rtl/reg_dump_reader.sv | 117 +++++++++++
 2 files changed

// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader.
//   NUM_REGS / ADDR_W / DATA_W match the 32x32 register file.
//   OUT_W is the byte-stream beat width.
//   state_t holds the reader FSM encoding. The values are fixed so the
//   encoding stays identical to the original localparam constants.
package reg_dump_reader_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned OUT_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// Debug read-out engine for the register file.
// A start pulse walks x0..x(NUM_REGS-1) through one combinational read port.
// Each word is snapshotted in its own LOAD cycle and then streamed out
// LSB-beat-first over a valid/ready interface. This block never writes the
// register file.
//
// Ports:
//   clock, reset         posedge clock; reset is asynchronous and active-high
//   start                begins a dump; only sampled in IDLE
//   abort                synchronous cancel from any state back to IDLE
//   busy                 high in LOAD and SEND
//   done                 one-cycle pulse after the last beat is accepted
//   rd_addr / rd_data    register file read port (combinational read)
//   out_valid/out_ready  beat handshake
//   out_data             current beat
//   out_last             marks the final beat of the final register
module reg_dump_reader #(
  parameter int unsigned NUM_REGS = reg_dump_reader_pkg::NUM_REGS,
  parameter int unsigned ADDR_W   = reg_dump_reader_pkg::ADDR_W,
  parameter int unsigned DATA_W   = reg_dump_reader_pkg::DATA_W,
  parameter int unsigned OUT_W    = reg_dump_reader_pkg::OUT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last
);
  import reg_dump_reader_pkg::*;

  localparam int unsigned BEATS  = DATA_W / OUT_W;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q,   idx_d;
  logic [BEAT_W-1:0]   beat_q,  beat_d;
  logic [DATA_W-1:0]   shift_q, shift_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      beat_q  <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    shift_d = shift_q;
    // abort outranks start and the handshake. The shift register is left
    // as-is because nothing reads it until the next LOAD.
    if (abort) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      beat_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_LOAD;
            idx_d   = '0;
          end
        end
        ST_LOAD: begin
          shift_d = rd_data;
          beat_d  = '0;
          state_d = ST_SEND;
        end
        ST_SEND: begin
          if (out_ready) begin
            if (beat_q != LAST_BEAT) begin
              shift_d = shift_q >> OUT_W;
              beat_d  = beat_q + 1'b1;
            end else if (idx_q != LAST_IDX) begin
              idx_d   = idx_q + 1'b1;
              state_d = ST_LOAD;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // All outputs decode from registered state, so an asynchronous reset
  // clears them at once without waiting for a clock edge.
  assign rd_addr   = idx_q;
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_SEND);
  assign done      = (state_q == ST_DONE);
  assign out_valid = (state_q == ST_SEND);
  assign out_data  = shift_q[OUT_W-1:0];
  assign out_last  = (state_q == ST_SEND) && (beat_q == LAST_BEAT) && (idx_q == LAST_IDX);

endmodule
